// File: rtl/multicycle_main_control.sv
// Multi-cycle RV32I main control FSM with memory-timeout and illegal-opcode traps.
// Optional retired-instruction counter o_InstrRet: define MAIN_CTRL_PERF_CNT_EN.
module multicycle_main_control #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int WAIT_W      = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [6:0]         i_OPCode,
  input  logic               i_MemReady,
  output logic               o_PCWrite,
  output logic               o_IRWrite,
  output logic               o_IorD,
  output logic               o_Branch,
  output logic               o_MemRead,
  output logic               o_MemWrite,
  output logic [1:0]         o_MemToReg,
  output logic [ALUOP_W-1:0] o_ALUOp,
  output logic [1:0]         o_ALUSrcA,
  output logic [1:0]         o_ALUSrcB,
  output logic               o_RegWrite,
  output logic               o_IllegalInstr,
  output logic               o_BusErr
`ifdef MAIN_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]        o_InstrRet
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC,
    S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_BR  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_I   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_B   = ALUOP_W'(4);

  state_t            r_state;
  state_t            w_next;
  logic [6:0]        r_opcode;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              r_illegal;
  logic              r_buserr;
  logic              w_known;
  logic              w_waiting;
  logic              w_timeout;
  logic              w_retire;

  logic w_r, w_i, w_ld, w_st, w_br;
  logic w_jal, w_jalr, w_lui, w_auipc;

  assign w_r     = (r_opcode == OP_R);
  assign w_i     = (r_opcode == OP_I);
  assign w_ld    = (r_opcode == OP_LD);
  assign w_st    = (r_opcode == OP_ST);
  assign w_br    = (r_opcode == OP_BR);
  assign w_jal   = (r_opcode == OP_JAL);
  assign w_jalr  = (r_opcode == OP_JALR);
  assign w_lui   = (r_opcode == OP_LUI);
  assign w_auipc = (r_opcode == OP_AUIPC);

  assign w_known = (i_OPCode == OP_R)   || (i_OPCode == OP_I)
                || (i_OPCode == OP_LD)  || (i_OPCode == OP_ST)
                || (i_OPCode == OP_BR)  || (i_OPCode == OP_JAL)
                || (i_OPCode == OP_JALR)|| (i_OPCode == OP_LUI)
                || (i_OPCode == OP_AUIPC);

  // The limit is hit on the edge where the count would reach MEM_TIMEOUT.
  assign w_waiting  = (r_state == S_FETCH || r_state == S_MEM)
                   && !i_MemReady;
  assign w_wait_inc = r_wait + 1'b1;
  assign w_timeout  = (MEM_TIMEOUT != 0) && w_waiting
                   && (w_wait_inc == WAIT_W'(MEM_TIMEOUT));

  assign w_retire = (w_next == S_FETCH)
                 && (r_state == S_WB || r_state == S_EXEC
                     || r_state == S_MEM);

  // State, latched opcode, wait counter and sticky trap flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_opcode  <= '0;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_buserr  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= i_OPCode;
      r_wait <= w_waiting ? w_wait_inc : '0;
      if (r_state == S_DECODE && !w_known) r_illegal <= 1'b1;
      if (w_timeout) r_buserr <= 1'b1;
    end
  end

  // Next-state sequencing.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH: begin
        if (i_MemReady)     w_next = S_DECODE;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_DECODE: w_next = w_known ? S_EXEC : S_TRAP;
      S_EXEC: begin
        unique case (1'b1)
          w_ld, w_st: w_next = S_MEM;
          w_br:       w_next = S_FETCH;
          default:    w_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (i_MemReady)     w_next = w_ld ? S_WB : S_FETCH;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_WB:     w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath strobes decoded from state and latched opcode.
  always_comb begin
    o_PCWrite  = 1'b0;
    o_IRWrite  = 1'b0;
    o_IorD     = 1'b0;
    o_Branch   = 1'b0;
    o_MemRead  = 1'b0;
    o_MemWrite = 1'b0;
    o_MemToReg = 2'b00;
    o_ALUOp    = ALU_ADD;
    o_ALUSrcA  = 2'b00;
    o_ALUSrcB  = 2'b00;
    o_RegWrite = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        o_MemRead = 1'b1;
        if (i_MemReady) begin
          o_IRWrite = 1'b1;
          o_PCWrite = 1'b1;
          o_ALUSrcB = 2'b10;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          w_r: begin
            o_ALUSrcA = 2'b01;
            o_ALUOp   = ALU_R;
          end
          w_i: begin
            o_ALUSrcA = 2'b01;
            o_ALUSrcB = 2'b01;
            o_ALUOp   = ALU_I;
          end
          w_ld, w_st: begin
            o_ALUSrcA = 2'b01;
            o_ALUSrcB = 2'b01;
          end
          w_br: begin
            o_ALUSrcA = 2'b01;
            o_ALUOp   = ALU_BR;
            o_Branch  = 1'b1;
          end
          w_jal: begin
            o_ALUSrcB = 2'b01;
            o_PCWrite = 1'b1;
          end
          w_jalr: begin
            o_ALUSrcA = 2'b01;
            o_ALUSrcB = 2'b01;
            o_PCWrite = 1'b1;
          end
          w_lui: begin
            o_ALUSrcA = 2'b10;
            o_ALUSrcB = 2'b01;
            o_ALUOp   = ALU_B;
          end
          w_auipc: o_ALUSrcB = 2'b01;
          default: ;
        endcase
      end
      S_MEM: begin
        o_IorD     = 1'b1;
        o_MemRead  = w_ld;
        o_MemWrite = w_st;
      end
      S_WB: begin
        o_RegWrite = 1'b1;
        if (w_ld)               o_MemToReg = 2'b01;
        else if (w_jal||w_jalr) o_MemToReg = 2'b10;
      end
      default: ;
    endcase
  end

  assign o_IllegalInstr = r_illegal;
  assign o_BusErr       = r_buserr;

`ifdef MAIN_CTRL_PERF_CNT_EN
  logic [31:0] r_instret;

  // Count instructions retiring back into FETCH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end

  assign o_InstrRet = r_instret;
`else
  logic w_unused;
  assign w_unused = w_retire;
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Randomized bench for multicycle_main_control against a phase-level model.
// Build with MAIN_CTRL_PERF_CNT_EN to also check o_InstrRet.
module tb_multicycle_main_control;

  localparam int TO = 15;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [6:0] i_OPCode = '0;
  logic       i_MemReady = 1'b0;
  logic       o_PCWrite, o_IRWrite, o_IorD, o_Branch;
  logic       o_MemRead, o_MemWrite, o_RegWrite;
  logic [1:0] o_MemToReg, o_ALUSrcA, o_ALUSrcB;
  logic [2:0] o_ALUOp;
  logic       o_IllegalInstr, o_BusErr;
`ifdef MAIN_CTRL_PERF_CNT_EN
  logic [31:0] o_InstrRet;
`endif

  multicycle_main_control #(
    .ALUOP_W(3), .MEM_TIMEOUT(TO), .WAIT_W(4)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_OPCode(i_OPCode), .i_MemReady(i_MemReady),
    .o_PCWrite(o_PCWrite), .o_IRWrite(o_IRWrite),
    .o_IorD(o_IorD), .o_Branch(o_Branch),
    .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite),
    .o_MemToReg(o_MemToReg), .o_ALUOp(o_ALUOp),
    .o_ALUSrcA(o_ALUSrcA), .o_ALUSrcB(o_ALUSrcB),
    .o_RegWrite(o_RegWrite),
    .o_IllegalInstr(o_IllegalInstr), .o_BusErr(o_BusErr)
`ifdef MAIN_CTRL_PERF_CNT_EN
    , .o_InstrRet(o_InstrRet)
`endif
  );

  always #5 i_clk = ~i_clk;

  logic [17:0] obs;
  assign obs = {o_PCWrite, o_IRWrite, o_IorD, o_Branch,
                o_MemRead, o_MemWrite, o_MemToReg, o_ALUOp,
                o_ALUSrcA, o_ALUSrcB, o_RegWrite,
                o_IllegalInstr, o_BusErr};

  int n_chk = 0;
  int n_err = 0;
  bit m_ill = 0;
  bit m_bus = 0;
  int unsigned m_ret = 0;

  logic [6:0] legal [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                            7'b0100011, 7'b1100011, 7'b1101111,
                            7'b1100111, 7'b0110111, 7'b0010111};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    foreach (legal[k]) if (legal[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] mk(
    input bit pcw, input bit irw, input bit iord, input bit br,
    input bit mr, input bit mw, input logic [1:0] m2r,
    input logic [2:0] alu, input logic [1:0] sa,
    input logic [1:0] sb, input bit rw);
    return {pcw, irw, iord, br, mr, mw, m2r, alu, sa, sb, rw};
  endfunction

  task automatic step(input logic rdy, input logic [15:0] ctl,
                      input string tag);
    i_MemReady = rdy;
    @(negedge i_clk);
    check(tag, 32'(obs), 32'({ctl, m_ill, m_bus}));
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_ret(input string tag);
`ifdef MAIN_CTRL_PERF_CNT_EN
    check(tag, o_InstrRet, m_ret);
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  task automatic trap_hold();
    for (int k = 0; k < 3; k++)
      step(1'($urandom_range(0, 1)), 16'h0, "trap");
    chk_ret("ret_trap");
  endtask

  task automatic do_reset();
    #2;
    i_rst_n = 1'b0;
    #2;
    m_ill = 0;
    m_bus = 0;
    m_ret = 0;
    check("rst_out", 32'(obs), 32'h0);
    chk_ret("ret_rst");
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    step(1'b1, 16'h0, "idle");
  endtask

  // Wait-phase model: n zero-ready cycles; the 15th consecutive one traps.
  task automatic waits(input int n, input logic [15:0] ctl,
                       input string tag, output bit tr);
    tr = 0;
    for (int k = 0; k < n && !tr; k++) begin
      step(1'b0, ctl, tag);
      if (k == TO - 1) begin
        m_bus = 1;
        tr = 1;
      end
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw,
                           input int mw, output bit tr);
    logic [15:0] ex, mc;
    logic [1:0]  m2r;
    int          nxt;
    tr = 0;
    i_OPCode = op;
    waits(fw, mk(0,0,0,0,1,0,0,0,0,0,0), "fetch_wait", tr);
    if (tr) begin trap_hold(); return; end
    step(1'b1, mk(1,1,0,0,1,0,0,0,0,2,0), "fetch_rdy");
    step(1'($urandom_range(0, 1)), 16'h0, "decode");
    i_OPCode = 7'($urandom);
    if (!is_legal(op)) begin
      m_ill = 1;
      tr = 1;
      trap_hold();
      return;
    end
    m2r = 2'b00;
    mc  = 16'h0;
    nxt = 0;
    case (op)
      7'b0110011: ex = mk(0,0,0,0,0,0,0,2,1,0,0);
      7'b0010011: ex = mk(0,0,0,0,0,0,0,3,1,1,0);
      7'b0000011: begin
        ex = mk(0,0,0,0,0,0,0,0,1,1,0);
        mc = mk(0,0,1,0,1,0,0,0,0,0,0);
        nxt = 1; m2r = 2'b01;
      end
      7'b0100011: begin
        ex = mk(0,0,0,0,0,0,0,0,1,1,0);
        mc = mk(0,0,1,0,0,1,0,0,0,0,0);
        nxt = 1;
      end
      7'b1100011: begin
        ex = mk(0,0,0,1,0,0,0,1,1,0,0);
        nxt = 2;
      end
      7'b1101111: begin
        ex = mk(1,0,0,0,0,0,0,0,0,1,0); m2r = 2'b10;
      end
      7'b1100111: begin
        ex = mk(1,0,0,0,0,0,0,0,1,1,0); m2r = 2'b10;
      end
      7'b0110111: ex = mk(0,0,0,0,0,0,0,4,2,1,0);
      default:    ex = mk(0,0,0,0,0,0,0,0,0,1,0);
    endcase
    step(1'($urandom_range(0, 1)), ex, "exec");
    if (nxt == 1) begin
      waits(mw, mc, "mem_wait", tr);
      if (tr) begin trap_hold(); return; end
      step(1'b1, mc, "mem_rdy");
      if (op == 7'b0100011) nxt = 2;
    end
    if (nxt != 2)
      step(1'($urandom_range(0, 1)),
           mk(0,0,0,0,0,0,m2r,0,0,0,1), "wb");
    m_ret++;
    chk_ret("ret");
  endtask

  function automatic int wsel();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return 14;
    if (r == 1) return 15;
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    bit tr;
    do_reset();
    run_instr(7'b0110011, 0, 0, tr);
    run_instr(7'b0000011, 0, 3, tr);
    run_instr(7'b0100011, 1, 0, tr);
    run_instr(7'b1100011, 0, 0, tr);
    run_instr(7'b1101111, 0, 0, tr);
    run_instr(7'b0110111, 0, 0, tr);
    run_instr(7'b1111111, 0, 0, tr);
    do_reset();
    run_instr(7'b0110011, 15, 0, tr);
    do_reset();
    run_instr(7'b0110011, 14, 0, tr);
    run_instr(7'b0000011, 0, 15, tr);
    do_reset();
    run_instr(7'b0100011, 2, 14, tr);
    for (int n = 0; n < 300; n++) begin
      logic [6:0] op;
      int fw, mw;
      if ($urandom_range(0, 15) == 0) op = 7'($urandom);
      else op = legal[$urandom_range(0, 8)];
      fw = wsel();
      mw = wsel();
      run_instr(op, fw, mw, tr);
      if (tr) do_reset();
    end
    run_instr(7'b0010111, 0, 0, tr);
    i_OPCode = 7'b0000011;
    step(1'b1, mk(1,1,0,0,1,0,0,0,0,2,0), "mm_fetch");
    step(1'b0, 16'h0, "mm_decode");
    step(1'b0, mk(0,0,0,0,0,0,0,0,1,1,0), "mm_exec");
    step(1'b0, mk(0,0,1,0,1,0,0,0,0,0,0), "mm_mem");
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multi-cycle successor to the single-cycle RV32I main decoder.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with a ready handshake to unified memory.
- Decodes the full RV32I base opcode set (R, I, load, store, branch, JAL, JALR, LUI, AUIPC) into datapath strobes.
- Sits between the instruction register and the multi-cycle datapath; adds a memory-timeout trap and an illegal-opcode trap.

Parameters:
- ALUOP_W, 3, width of o_ALUOp (minimum 3).
- MEM_TIMEOUT, 15, max wait cycles for i_MemReady before bus-error trap; 0 disables the timeout.
- WAIT_W, 4, width of the wait counter; must satisfy 2^WAIT_W > MEM_TIMEOUT.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_OPCode  in  7  instruction[6:0]; valid from DECODE onward (IR output).
- i_MemReady  in  1  memory completes current access this cycle.
- o_PCWrite  out  1  load PC (PC+4 in FETCH, target in EXEC for jumps).
- o_IRWrite  out  1  load instruction register.
- o_IorD  out  1  memory address: 0 = PC, 1 = ALU result.
- o_Branch  out  1  conditional PC load if ALU zero/compare true.
- o_MemRead  out  1  memory read strobe.
- o_MemWrite  out  1  memory write strobe.
- o_MemToReg  out  2  writeback select: 00 ALU, 01 memory data, 10 PC+4.
- o_ALUOp  out  ALUOP_W  000 add, 001 branch compare, 010 R funct, 011 I funct, 100 pass B.
- o_ALUSrcA  out  2  00 old PC, 01 rs1, 10 zero.
- o_ALUSrcB  out  2  00 rs2, 01 immediate, 10 constant 4.
- o_RegWrite  out  1  register-file write.
- o_IllegalInstr  out  1  sticky illegal-opcode trap flag.
- o_BusErr  out  1  sticky memory-timeout trap flag.

Behaviour:
- States: S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP.
- Outputs are Moore-decoded from state and the opcode latched in DECODE, except the FETCH/MEM completion strobes, which are additionally qualified by i_MemReady.
- Reset (async, i_rst_n low): state = S_IDLE, latched opcode = 0, wait counter = 0, both trap flags = 0. All outputs are 0 in S_IDLE. S_IDLE always moves to S_FETCH on the next edge.
- S_FETCH:
  - Drives o_MemRead=1, o_IorD=0.
  - When i_MemReady=1: o_IRWrite=1, o_PCWrite=1, o_ALUSrcA=00, o_ALUSrcB=10, ALUOp add; next S_DECODE.
  - Otherwise stays in S_FETCH.
- S_DECODE:
  - Latches i_OPCode.
  - Unknown opcode: next S_TRAP and set o_IllegalInstr.
  - Known opcode: next S_EXEC.
- S_EXEC:
  - R: SrcA=01, SrcB=00, ALUOp 010; next S_WB.
  - I: SrcA=01, SrcB=01, ALUOp 011; next S_WB.
  - Load/store: SrcA=01, SrcB=01, add; next S_MEM.
  - Branch: SrcA=01, SrcB=00, ALUOp 001, o_Branch=1 for exactly one cycle; next S_FETCH.
  - JAL: SrcA=00, SrcB=01, add, o_PCWrite=1; next S_WB.
  - JALR: SrcA=01, SrcB=01, add, o_PCWrite=1; next S_WB.
  - LUI: SrcA=10, SrcB=01, ALUOp 100; next S_WB.
  - AUIPC: SrcA=00, SrcB=01, add; next S_WB.
- S_MEM:
  - o_IorD=1; o_MemRead=1 for load, o_MemWrite=1 for store; strobes held until i_MemReady.
  - Load: on ready, next S_WB.
  - Store: on ready, next S_FETCH.
- S_WB:
  - o_RegWrite=1 for exactly one cycle; next S_FETCH.
  - o_MemToReg = 01 for load, 10 for JAL/JALR, 00 otherwise.
- S_TRAP: all strobes 0; trap flags held; left only by reset.
- Wait counter:
  - Cleared on entry to S_FETCH/S_MEM and whenever i_MemReady=1.
  - Increments each waiting cycle.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with i_MemReady still 0: next S_TRAP, set o_BusErr.
  - i_MemReady=1 in the same cycle as the limit is reached wins (no trap).
- CPI: ALU op 4, branch 3, load 5, store 4 (zero-wait memory).
- Reset mid-access drops all strobes immediately; execution restarts at S_IDLE.

Optional Feature:
- Macro: MAIN_CTRL_PERF_CNT_EN.
- Defined: adds output port o_InstrRet (32 bits), reset to 0. It increments by 1 on every transition into S_FETCH from S_WB, S_EXEC (branch) or S_MEM (store), and wraps modulo 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with i_MemReady=1: after release, 1 cycle S_IDLE, then o_MemRead=1; add (0110011) -> o_RegWrite=1 in cycle 4 of the instruction, o_MemToReg=00, o_ALUOp=010.
- Load (0000011), i_MemReady low 3 cycles in S_MEM -> o_MemRead/o_IorD held 3 cycles, then S_WB with o_MemToReg=01, o_RegWrite=1 one cycle.
- Store (0100011) then branch (1100011) -> o_MemWrite=1 with o_IorD=1 and never o_RegWrite; branch gives o_Branch=1 exactly one cycle, 3-cycle CPI.
- JAL (1101111) -> o_PCWrite=1 in EXEC, then o_MemToReg=10 with o_RegWrite=1; LUI (0110111) -> o_ALUSrcA=10, o_ALUOp=100.
- Opcode 1111111 -> o_IllegalInstr=1 after DECODE and held; i_MemReady held 0 in FETCH 15 cycles -> o_BusErr=1; 14 cycles then ready -> no trap.
- With MAIN_CTRL_PERF_CNT_EN: 5 mixed instructions -> o_InstrRet=5; async reset mid-S_MEM -> all outputs 0 immediately, counter 0.
